// File: rtl/playfield_tx.sv
// playfield_tx: serialises a playfield snapshot into a SYNC/seq/payload/checksum byte frame over valid/ready
module playfield_tx #(
  parameter int PLAYFIELD_DIM_X = 10,
  parameter int PLAYFIELD_DIM_Y = 20,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                                       clk,
  input  logic                                       rst_l,
  input  logic [PLAYFIELD_DIM_Y*PLAYFIELD_DIM_X*3-1:0] playfield,
  input  logic                                       send,
  output logic                                       busy,
  output logic                                       done,
  output logic [7:0]                                 seq_num,
  output logic [7:0]                                 tx_data,
  output logic                                       tx_valid,
  input  logic                                       tx_ready
);
  localparam int W = PLAYFIELD_DIM_Y*PLAYFIELD_DIM_X*3;
  localparam int NB = PLAYFIELD_DIM_X*PLAYFIELD_DIM_Y/2;
  localparam int CW = $clog2(NB);
  typedef enum logic [2:0] {IDLE, SYNC, SEQ, PAYLOAD, CSUM} state_t;
  state_t state, state_n;
  logic [W-1:0] snap;
  logic [CW-1:0] cnt;
  logic [7:0] csum, pb;
  logic hs;
  assign hs = tx_valid && tx_ready;
  // the snapshot shifts down one tile pair per payload byte, so the current pair is always at the bottom
  assign pb = {1'b0, snap[2:0], 1'b0, snap[5:3]};
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = send ? SYNC : IDLE;
      SYNC:    state_n = hs ? SEQ : SYNC;
      SEQ:     state_n = hs ? PAYLOAD : SEQ;
      PAYLOAD: state_n = (hs && cnt == CW'(NB-1)) ? CSUM : PAYLOAD;
      CSUM:    state_n = hs ? IDLE : CSUM;
      default: state_n = IDLE;
    endcase
    busy = state != IDLE;
    tx_valid = state != IDLE;
    tx_data = state == SYNC ? SYNC_BYTE :
              state == SEQ ? seq_num :
              state == PAYLOAD ? pb :
              state == CSUM ? csum : 8'h00;
  end
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      snap <= '0;
      cnt <= '0;
      csum <= 8'h00;
      seq_num <= 8'h00;
      done <= 1'b0;
    end else begin
      done <= state == CSUM && hs;
      if (state == IDLE && send) begin
        snap <= playfield;
        cnt <= '0;
        csum <= 8'h00;
      end
      if (state == SEQ && hs) csum <= csum ^ seq_num;
      if (state == PAYLOAD && hs) begin
        csum <= csum ^ pb;
        snap <= snap >> 6;
        cnt <= cnt + CW'(1);
      end
      if (state == CSUM && hs) seq_num <= seq_num + 8'd1;
    end
endmodule

// File: tb/tb_playfield_tx.sv
// tb_playfield_tx: directed vector table plus multi-cycle sequences for playfield_tx
module tb_playfield_tx;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic send = 1'b0;
  logic tx_ready = 1'b0;
  logic [599:0] pf = '0;
  logic [599:0] pf_save;
  logic busy, done, tx_valid;
  logic [7:0] seq_num, tx_data;
  logic [2:0] tiles [20][10];
  logic [7:0] got [103];
  logic [7:0] exp_f [103];
  int checks = 0;
  int fails = 0;
  int busy_cyc;
  typedef struct {
    int r;
    int c;
    logic [2:0] t0;
    logic [2:0] t1;
    int idx;
    logic [7:0] pb;
    logic [7:0] seq;
    logic [7:0] cs;
  } vec_t;
  vec_t vt [6];

  playfield_tx dut (
    .clk(clk), .rst_l(rst_l), .playfield(pf), .send(send), .busy(busy), .done(done),
    .seq_num(seq_num), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic clear_pf();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) tiles[r][c] = 3'd0;
    pf = '0;
  endtask

  task automatic set_tile(input int r, input int c, input logic [2:0] t);
    tiles[r][c] = t;
    pf[(r*10+c)*3 +: 3] = t;
  endtask

  task automatic build_exp(input logic [7:0] s);
    logic [7:0] cs, b;
    exp_f[0] = 8'hA5;
    exp_f[1] = s;
    cs = s;
    for (int k = 0; k < 100; k++) begin
      b = {1'b0, tiles[k/5][(k%5)*2], 1'b0, tiles[k/5][(k%5)*2+1]};
      exp_f[2+k] = b;
      cs = cs ^ b;
    end
    exp_f[102] = cs;
  endtask

  task automatic cmp_frame(input string nm);
    int bad, first;
    bad = 0;
    first = -1;
    for (int i = 0; i < 103; i++)
      if (got[i] !== exp_f[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d bytes differ, byte %0d got %0h expected %0h", nm, bad, first, got[first], exp_f[first]);
    end
  endtask

  task automatic start();
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  // mode 0: ready always; mode 1: random backpressure with long SYNC/CSUM stalls; mode 2: mid-frame send and playfield change
  task automatic recv(input int mode);
    int cnt, cyc, stall;
    logic pstall, drop, moved;
    logic [7:0] pdata;
    cnt = 0; cyc = 0; stall = 0;
    pstall = 1'b0; drop = 1'b0; moved = 1'b0; pdata = 8'h00;
    busy_cyc = 0;
    while (cnt < 103 && cyc < 5000) begin
      if (mode == 2) begin
        send = (cnt == 30);
        if (cnt == 50) pf = {200{3'd7}};
      end
      if (mode == 1) begin
        if ((cnt == 0 || cnt == 102) && stall < 20) begin
          tx_ready = 1'b0;
          stall++;
        end else tx_ready = ($urandom_range(0, 2) != 0);
      end else tx_ready = 1'b1;
      if (busy) busy_cyc++;
      if (cnt > 0 && !tx_valid) drop = 1'b1;
      if (pstall && tx_data !== pdata) moved = 1'b1;
      pstall = tx_valid && !tx_ready;
      pdata = tx_data;
      if (tx_valid && tx_ready) begin
        got[cnt] = tx_data;
        cnt++;
        stall = 0;
      end
      cyc++;
      @(negedge clk);
    end
    send = 1'b0;
    tx_ready = 1'b0;
    chk("frame_len", cnt, 103);
    chk("valid_held", drop, 0);
    chk("data_stable", moved, 0);
  endtask

  initial begin
    int n, cyc, len_ok;
    logic dn;
    logic [7:0] sb, s_ff;
    vt[0] = '{0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 8'h00};
    vt[1] = '{0, 0, 3'd1, 3'd7, 0, 8'h17, 8'h01, 8'h16};
    vt[2] = '{19, 8, 3'd3, 3'd2, 99, 8'h32, 8'h02, 8'h30};
    vt[3] = '{5, 4, 3'd5, 3'd6, 27, 8'h56, 8'h03, 8'h55};
    vt[4] = '{10, 2, 3'd4, 3'd0, 51, 8'h40, 8'h04, 8'h44};
    vt[5] = '{0, 6, 3'd7, 3'd7, 3, 8'h77, 8'h05, 8'h72};
    clear_pf();
    repeat (3) @(negedge clk);
    chk("rst_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_seq", seq_num, 0);
    chk("rst_data", tx_data, 0);
    rst_l = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      clear_pf();
      set_tile(vt[i].r, vt[i].c, vt[i].t0);
      set_tile(vt[i].r, vt[i].c + 1, vt[i].t1);
      build_exp(vt[i].seq);
      start();
      chk("latency_sync", {tx_valid, tx_data}, {1'b1, 8'hA5});
      recv(0);
      chk("busy_cycles", busy_cyc, 103);
      chk("done_pulse", {done, busy}, 2'b10);
      chk("seq_byte", got[1], vt[i].seq);
      chk("payload_byte", got[2 + vt[i].idx], vt[i].pb);
      chk("checksum", got[102], vt[i].cs);
      cmp_frame("vec_frame");
      @(negedge clk);
      chk("done_single", done, 0);
      chk("seq_incr", seq_num, vt[i].seq + 8'd1);
    end

    clear_pf();
    set_tile(0, 0, 3'd1);
    set_tile(0, 1, 3'd7);
    set_tile(19, 8, 3'd3);
    set_tile(19, 9, 3'd2);
    build_exp(8'h06);
    start();
    recv(0);
    chk("t2_csum", got[102], 8'h23);
    cmp_frame("t2_frame");
    @(negedge clk);
    build_exp(8'h07);
    start();
    recv(0);
    chk("t3_seq", got[1], 8'h07);
    chk("t3_csum", got[102], 8'h22);
    cmp_frame("t3_frame");
    chk("t3_seq_next", seq_num, 8'h08);
    @(negedge clk);

    build_exp(8'h08);
    start();
    recv(1);
    chk("bp_csum", got[102], 8'h2D);
    cmp_frame("bp_frame");
    @(negedge clk);

    pf_save = pf;
    build_exp(8'h09);
    start();
    recv(2);
    chk("iso_csum", got[102], 8'h2C);
    cmp_frame("iso_frame");
    chk("iso_done", done, 1);
    pf = pf_save;
    build_exp(8'h0A);
    start();
    chk("b2b_sync", {tx_valid, tx_data}, {1'b1, 8'hA5});
    recv(0);
    cmp_frame("b2b_frame");
    @(negedge clk);
    chk("b2b_idle", tx_valid, 0);

    start();
    tx_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 42 && cyc < 200) begin
      if (tx_valid) n++;
      cyc++;
      @(negedge clk);
    end
    chk("abort_reach", n, 42);
    rst_l = 1'b0;
    #1;
    chk("abort_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_seq", seq_num, 0);
    dn = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || tx_valid) dn = 1'b1;
    end
    rst_l = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done || tx_valid) dn = 1'b1;
    end
    chk("abort_quiet", dn, 0);
    tx_ready = 1'b0;

    len_ok = 1;
    sb = 8'h00;
    s_ff = 8'h00;
    for (int f = 0; f < 256; f++) begin
      start();
      tx_ready = 1'b1;
      n = 0; cyc = 0;
      while (n < 103 && cyc < 200) begin
        if (tx_valid) begin
          if (n == 1) sb = tx_data;
          n++;
        end
        cyc++;
        @(negedge clk);
      end
      if (n != 103) len_ok = 0;
      if (f == 254) s_ff = seq_num;
    end
    tx_ready = 1'b0;
    chk("wrap_lengths", len_ok, 1);
    chk("wrap_seq_ff", s_ff, 8'hFF);
    chk("wrap_last_seq_byte", sb, 8'hFF);
    chk("wrap_seq_00", seq_num, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/playfield_tx.md
Name: playfield_tx

Overview:
Serialises a snapshot of the local 10x20 playfield into a framed byte stream, for sending to the opponent board in versus mode. It is the sending end of the link; the peer's playfield receiver decodes the frame and feeds its display. The block sits between game logic, which owns the live playfield, and the link PHY/UART byte interface. The byte interface uses a valid/ready handshake.

Parameters:
PLAYFIELD_DIM_X, 10, tiles per row; must be even.
PLAYFIELD_DIM_Y, 20, rows per playfield.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clk  input  1  system clock
rst_l  input  1  asynchronous active-low reset
playfield  input  DIM_Y*DIM_X*3  live tile array [row][col] of tile_type_t (BLANK=0, I=1, O=2, T=3, J=4, L=5, S=6, Z=7)
send  input  1  single-cycle request to transmit one frame
busy  output  1  high from the accepted send until the final byte handshake
done  output  1  one-cycle pulse after the frame completes
seq_num  output  8  sequence number of the next frame to be sent
tx_data  output  8  stream byte
tx_valid  output  1  tx_data is valid
tx_ready  input  1  sink accepts the byte when tx_valid && tx_ready

Behaviour:
- Reset (async, rst_l=0): state IDLE; busy=0, done=0, tx_valid=0, tx_data=0, seq_num=0; snapshot cleared. A reset mid-frame abandons the frame with no further bytes and no done pulse.
- Frame is 3 + DIM_X*DIM_Y/2 bytes (103 at default):
  - SYNC_BYTE
  - seq_num
  - payload bytes
  - checksum
- Payload order: row 0 first, then row 1 and so on; within each row, col 0 upward in pairs.
- Payload byte for a pair = {1'b0, tile[c], 1'b0, tile[c+1]}: the even column goes in the high nibble, and bit 7 and bit 3 are always 0.
- Checksum = XOR of the seq byte and all payload bytes; SYNC_BYTE is excluded.
- FSM states: IDLE, SYNC, SEQ, PAYLOAD, CSUM.
  - IDLE: on send=1, capture playfield into the snapshot register at that edge, go to SYNC, busy=1.
  - SYNC, SEQ and CSUM each hold for exactly one handshake.
  - PAYLOAD: a byte counter runs from 0 to DIM_X*DIM_Y/2-1; the state advances on the handshake at the last index.
  - CSUM: on handshake go to IDLE, busy=0, increment seq_num (8-bit wrap FF->00), and assert done for exactly the next cycle.
- Latency: tx_valid is asserted with SYNC_BYTE in the cycle after send is sampled.
- Valid/ready rules:
  - tx_valid stays high continuously from SYNC through CSUM; it never drops mid-frame.
  - tx_data is stable while tx_valid && !tx_ready.
  - With tx_ready held at 1, one byte is transferred per cycle: 103 cycles per frame.
- Checksum accumulator: cleared at send, updated at each seq/payload handshake, and presented in CSUM. It is a registered value, so no combinational path exists from tx_ready to tx_data.
- The snapshot is isolated from the live array: changes to playfield while busy do not affect the frame in flight.
- send while busy=1 is ignored and not queued.
- send in the same cycle that done=1 (already IDLE) is accepted and starts the next frame, which carries the incremented seq_num.
- tx_ready is don't-care while tx_valid=0.

Test Plan:
1. All-BLANK playfield, seq 0, send pulse, tx_ready=1 -> stream A5, 00, 100 bytes of 00, checksum 00; busy high for 103 cycles; done pulses once in cycle 104.
2. row0 col0=I, col1=Z, row19 col8=T, col9=O; others BLANK -> payload[0]=17, payload[99]=32, all other payload bytes 00; checksum = 00^17^32 = 25.
3. Second frame after test 2 with the same playfield -> seq byte 01, checksum 24; seq_num increments 01->02 at done.
4. Random tx_ready backpressure, including long stalls on SYNC and CSUM -> tx_valid never drops mid-frame; tx_data holds while stalled; byte sequence is identical to test 2.
5. send re-pulsed mid-frame, and playfield changed to all-Z mid-frame -> no restart; frame still carries the original snapshot. send in the done cycle -> back-to-back frame starts with A5 the following cycle.
6. rst_l asserted at payload byte 40 -> tx_valid, busy and seq_num go to 0 immediately with no done pulse. Separately, 256 frames sent -> seq wraps FF->00.
